// File: rtl/pcecd_scsi_initiator.sv
// Initiator-side sequencer for the PCE CD drive bus: selection, command
// block transmission, DATA_IN sinking, STATUS/MESSAGE_IN capture and bus-free
// detection, with timeout and reset-pulse abort handling.
//
// Handshake rules:
//   - o_data/o_data_valid form a valid/ready pair: a byte transfers on a
//     clock edge where o_data_valid && i_data_ready. o_data_valid, once
//     raised, stays high with o_data stable until that edge.
//   - Toward the drive, o_ack rises only after REQ has been seen and stays
//     high until REQ falls. On the edge where REQ is seen low, o_ack falls.
//   - o_ack and o_sel are never high together.
`timescale 1ns/1ps
module pcecd_scsi_initiator #(
   parameter int MAX_CMD_BYTES = 10,
   parameter int TIMEOUT       = 4096,
   parameter int RST_CYCLES    = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_start,
   input  logic [8*MAX_CMD_BYTES-1:0] i_cmd_bytes,
   input  logic [3:0]                 i_cmd_len,
   input  logic                       i_abort,
   input  logic                       i_bsy,
   input  logic                       i_req,
   input  logic                       i_msg,
   input  logic                       i_cd,
   input  logic                       i_io,
   input  logic [7:0]                 i_db,
   output logic                       o_sel,
   output logic                       o_ack,
   output logic                       o_rst,
   output logic [7:0]                 o_db,
   output logic                       o_db_oe,
   output logic [7:0]                 o_data,
   output logic                       o_data_valid,
   input  logic                       i_data_ready,
   output logic [15:0]                o_data_count,
   output logic [7:0]                 o_status,
   output logic [7:0]                 o_message,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [1:0]                 o_err,
   output logic [2:0]                 o_state_dbg
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = $clog2(RST_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SELECT    = 3'd1,
      S_WAIT_REQ  = 3'd2,
      S_CMD_SETUP = 3'd3,   // DB driven, ACK follows next cycle
      S_DATA_WAIT = 3'd4,   // DATA_IN byte offered to the consumer
      S_ACK_HOLD  = 3'd5,   // ACK high until REQ falls
      S_ABORT     = 3'd6,
      S_DONE      = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      PH_CMD  = 2'd0,
      PH_DATA = 2'd1,
      PH_STAT = 2'd2,
      PH_MSG  = 2'd3
   } phase_t;

   state_t                      state_q, state_d;
   phase_t                      ph_q, ph_d;
   logic [8*MAX_CMD_BYTES-1:0]  cmd_q, cmd_d;
   logic [3:0]                  len_q, len_d;
   logic [3:0]                  idx_q, idx_d;
   logic                        cmd_over_q, cmd_over_d;
   logic                        msg_done_q, msg_done_d;
   logic                        done_en_q, done_en_d;
   logic [TW-1:0]               tmo_q, tmo_d;
   logic [RW-1:0]               rst_cnt_q, rst_cnt_d;
   logic [7:0]                  db_q, db_d;
   logic [7:0]                  data_q, data_d;
   logic [15:0]                 count_q, count_d;
   logic [7:0]                  status_q, status_d;
   logic [7:0]                  message_q, message_d;
   logic [1:0]                  err_q, err_d;

   logic                        tmo_exp;
   logic                        waiting;
   logic [7:0]                  cmd_byte;
   logic [2:0]                  phase_code;

   assign tmo_exp    = (tmo_q == TW'(TIMEOUT - 1));
   assign cmd_byte   = cmd_q[8*idx_q +: 8];
   assign phase_code = {i_msg, i_cd, i_io};

   // State and datapath registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         ph_q       <= PH_CMD;
         cmd_q      <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         cmd_over_q <= 1'b0;
         msg_done_q <= 1'b0;
         done_en_q  <= 1'b0;
         tmo_q      <= '0;
         rst_cnt_q  <= '0;
         db_q       <= '0;
         data_q     <= '0;
         count_q    <= '0;
         status_q   <= '0;
         message_q  <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         cmd_q      <= cmd_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         cmd_over_q <= cmd_over_d;
         msg_done_q <= msg_done_d;
         done_en_q  <= done_en_d;
         tmo_q      <= tmo_d;
         rst_cnt_q  <= rst_cnt_d;
         db_q       <= db_d;
         data_q     <= data_d;
         count_q    <= count_d;
         status_q   <= status_d;
         message_q  <= message_d;
         err_q      <= err_d;
      end
   end

   // Next-state, captures, timeout and reset-pulse counters
   always_comb begin
      state_d    = state_q;
      ph_d       = ph_q;
      cmd_d      = cmd_q;
      len_d      = len_q;
      idx_d      = idx_q;
      cmd_over_d = cmd_over_q;
      msg_done_d = msg_done_q;
      done_en_d  = done_en_q;
      db_d       = db_q;
      data_d     = data_q;
      count_d    = count_q;
      status_d   = status_q;
      message_d  = message_q;
      err_d      = err_q;

      case (state_q)
         S_IDLE: begin
            if (i_abort) begin
               // Bus reset only; no completion pulse for an idle abort.
               done_en_d = 1'b0;
               state_d   = S_ABORT;
            end else if (i_start) begin
               cmd_d      = i_cmd_bytes;
               // A zero length still sends one byte; oversize lengths clamp.
               if (i_cmd_len == 4'd0)
                  len_d = 4'd1;
               else if (i_cmd_len > 4'(MAX_CMD_BYTES))
                  len_d = 4'(MAX_CMD_BYTES);
               else
                  len_d = i_cmd_len;
               idx_d      = '0;
               cmd_over_d = 1'b0;
               msg_done_d = 1'b0;
               done_en_d  = 1'b1;
               err_d      = 2'd0;
               count_d    = '0;
               status_d   = '0;
               message_d  = '0;
               state_d    = S_SELECT;
            end
         end
         S_SELECT: begin
            if (i_bsy) begin
               state_d = S_WAIT_REQ;
            end else if (tmo_exp) begin
               err_d   = 2'd1;
               state_d = S_ABORT;
            end
         end
         S_WAIT_REQ: begin
            if (!i_bsy) begin
               if (msg_done_q) begin
                  state_d = S_DONE;
               end else begin
                  err_d   = 2'd3;
                  state_d = S_ABORT;
               end
            end else if (i_req) begin
               case (phase_code)
                  3'b010: begin
                     ph_d = PH_CMD;
                     // A request beyond the block gets a filler byte, then abort.
                     if (idx_q < len_q) begin
                        db_d = cmd_byte;
                     end else begin
                        db_d       = 8'h00;
                        cmd_over_d = 1'b1;
                     end
                     state_d = S_CMD_SETUP;
                  end
                  3'b001: begin
                     ph_d    = PH_DATA;
                     data_d  = i_db;
                     state_d = S_DATA_WAIT;
                  end
                  3'b011: begin
                     ph_d     = PH_STAT;
                     status_d = i_db;
                     state_d  = S_ACK_HOLD;
                  end
                  3'b111: begin
                     ph_d      = PH_MSG;
                     message_d = i_db;
                     state_d   = S_ACK_HOLD;
                  end
                  default: begin
                     err_d   = 2'd3;
                     state_d = S_ABORT;
                  end
               endcase
            end else if (tmo_exp) begin
               err_d   = 2'd2;
               state_d = S_ABORT;
            end
         end
         S_CMD_SETUP: begin
            // REQ withdrawn before ACK is a protocol violation.
            if (!i_req) begin
               err_d   = 2'd3;
               state_d = S_ABORT;
            end else begin
               state_d = S_ACK_HOLD;
            end
         end
         S_DATA_WAIT: begin
            if (!i_req) begin
               err_d   = 2'd3;
               state_d = S_ABORT;
            end else if (i_data_ready) begin
               state_d = S_ACK_HOLD;
            end
         end
         S_ACK_HOLD: begin
            if (!i_req) begin
               state_d = S_WAIT_REQ;
               case (ph_q)
                  PH_CMD: begin
                     idx_d = idx_q + 4'd1;
                     if (cmd_over_q) begin
                        err_d   = 2'd3;
                        state_d = S_ABORT;
                     end
                  end
                  PH_DATA: begin
                     if (count_q != 16'hFFFF)
                        count_d = count_q + 16'd1;
                  end
                  PH_MSG:  msg_done_d = 1'b1;
                  default: ;
               endcase
            end else if (tmo_exp) begin
               err_d   = 2'd2;
               state_d = S_ABORT;
            end
         end
         S_ABORT: begin
            if (rst_cnt_q == RW'(RST_CYCLES - 1))
               state_d = done_en_q ? S_DONE : S_IDLE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // External abort overrides everything outside IDLE and keeps the error code.
      if (i_abort && (state_q != S_IDLE) && (state_q != S_ABORT)) begin
         err_d   = err_q;
         state_d = S_ABORT;
      end

      // Timeout runs only while waiting on the target; any progress clears it.
      waiting   = (state_q == S_SELECT) || (state_q == S_WAIT_REQ) ||
                  (state_q == S_ACK_HOLD);
      tmo_d     = (waiting && (state_d == state_q)) ? tmo_q + TW'(1) : '0;
      rst_cnt_d = (state_q == S_ABORT) ? rst_cnt_q + RW'(1) : '0;
   end

   // Bus and status outputs decoded from registered state
   always_comb begin
      o_sel        = (state_q == S_SELECT);
      o_ack        = (state_q == S_ACK_HOLD);
      o_rst        = (state_q == S_ABORT);
      o_db_oe      = (state_q == S_CMD_SETUP) ||
                     ((state_q == S_ACK_HOLD) && (ph_q == PH_CMD));
      o_db         = db_q;
      o_data       = data_q;
      o_data_valid = (state_q == S_DATA_WAIT);
      o_data_count = count_q;
      o_status     = status_q;
      o_message    = message_q;
      o_busy       = (state_q != S_IDLE);
      o_done       = (state_q == S_DONE);
      o_err        = err_q;
      o_state_dbg  = state_q;
   end

endmodule

// File: tb/tb_pcecd_scsi_initiator.sv
// Bench for pcecd_scsi_initiator: a target-drive emulator driven by tasks,
// a DATA_IN consumer feeding a scoreboard, a per-cycle bus-rule checker,
// and directed plus randomized transactions.
`timescale 1ns/1ps
module tb_pcecd_scsi_initiator;

   localparam int MAXB    = 10;
   localparam int TIMEOUT = 4096;
   localparam int RSTC    = 16;

   localparam int SIG_SEL  = 0;
   localparam int SIG_ACK  = 1;
   localparam int SIG_RST  = 2;
   localparam int SIG_DONE = 3;

   localparam logic [2:0] PH_CMD  = 3'b010;
   localparam logic [2:0] PH_DATA = 3'b001;
   localparam logic [2:0] PH_STAT = 3'b011;
   localparam logic [2:0] PH_MSG  = 3'b111;

   logic              clk;
   logic              i_rst_n;
   logic              i_start;
   logic [8*MAXB-1:0] i_cmd_bytes;
   logic [3:0]        i_cmd_len;
   logic              i_abort;
   logic              i_bsy, i_req, i_msg, i_cd, i_io;
   logic [7:0]        i_db;
   logic              o_sel, o_ack, o_rst;
   logic [7:0]        o_db;
   logic              o_db_oe;
   logic [7:0]        o_data;
   logic              o_data_valid;
   logic              i_data_ready;
   logic [15:0]       o_data_count;
   logic [7:0]        o_status, o_message;
   logic              o_busy, o_done;
   logic [1:0]        o_err;
   logic [2:0]        o_state_dbg;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   logic [7:0] tc[MAXB];
   logic [7:0] td[8];
   int         hs_idx     = 0;
   int         stall_byte = -1;
   int         stall_cnt  = 0;
   bit         stalled    = 0;
   bit         rdy_random = 0;

   pcecd_scsi_initiator #(
      .MAX_CMD_BYTES(MAXB), .TIMEOUT(TIMEOUT), .RST_CYCLES(RSTC)
   ) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
      .i_cmd_bytes(i_cmd_bytes), .i_cmd_len(i_cmd_len), .i_abort(i_abort),
      .i_bsy(i_bsy), .i_req(i_req), .i_msg(i_msg), .i_cd(i_cd), .i_io(i_io),
      .i_db(i_db), .o_sel(o_sel), .o_ack(o_ack), .o_rst(o_rst), .o_db(o_db),
      .o_db_oe(o_db_oe), .o_data(o_data), .o_data_valid(o_data_valid),
      .i_data_ready(i_data_ready), .o_data_count(o_data_count),
      .o_status(o_status), .o_message(o_message), .o_busy(o_busy),
      .o_done(o_done), .o_err(o_err), .o_state_dbg(o_state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic sig(input int id);
      case (id)
         SIG_SEL:  return o_sel;
         SIG_ACK:  return o_ack;
         SIG_RST:  return o_rst;
         default:  return o_done;
      endcase
   endfunction

   task automatic wait_sig(input int id, input logic val, input int limit,
                           input string name, output bit ok);
      int n = 0;
      ok = 1'b1;
      while (sig(id) !== val) begin
         if (n >= limit) begin
            checks++;
            failures++;
            $display("FAIL %s timed out: signal=%0b required=%0b after %0d cycles", name, sig(id), val, n);
            ok = 1'b0;
            return;
         end
         @(negedge clk);
         n++;
      end
      checks++;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_sel"},    o_sel, 0);
      chk({tag, "_ack"},    o_ack, 0);
      chk({tag, "_rst"},    o_rst, 0);
      chk({tag, "_db"},     o_db, 0);
      chk({tag, "_db_oe"},  o_db_oe, 0);
      chk({tag, "_data"},   o_data, 0);
      chk({tag, "_dvalid"}, o_data_valid, 0);
      chk({tag, "_count"},  o_data_count, 0);
      chk({tag, "_status"}, o_status, 0);
      chk({tag, "_msg"},    o_message, 0);
      chk({tag, "_busy"},   o_busy, 0);
      chk({tag, "_done"},   o_done, 0);
      chk({tag, "_err"},    o_err, 0);
   endtask

   task automatic recover();
      i_req = 0; i_bsy = 0; i_abort = 0; i_start = 0;
      i_rst_n = 1'b0;
      tick(2);
      i_rst_n = 1'b1;
      exp_q.delete();
      tick(1);
   endtask

   // ---------------- DATA_IN consumer + scoreboard ----------------
   initial begin
      logic [7:0] e;
      i_data_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (o_data_valid && (hs_idx == stall_byte) && !stalled) begin
            stalled   = 1'b1;
            stall_cnt = 50;
         end
         if (stall_cnt > 0) begin
            i_data_ready = 1'b0;
            stall_cnt--;
            chk("stall_no_ack", o_ack, 0);
         end else begin
            i_data_ready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         if (i_rst_n && o_data_valid && i_data_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL data_unexpected actual=%0h required=no byte", o_data);
            end else begin
               e = exp_q.pop_front();
               if (o_data !== e) begin
                  failures++;
                  $display("FAIL data_byte actual=%0h expected=%0h", o_data, e);
               end
            end
            hs_idx++;
         end
      end
   end

   // ---------------- per-cycle bus rule checker ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (i_rst_n) begin
            chk("ack_sel_excl",   o_ack & o_sel, 0);
            chk("ack_needs_req",  o_ack & ~i_req, 0);
            chk("ack_valid_excl", o_ack & o_data_valid, 0);
            chk("oe_rst_excl",    o_db_oe & o_rst, 0);
            chk("busy_cover",     (o_sel | o_ack | o_rst | o_db_oe | o_data_valid) & ~o_busy, 0);
         end
      end
   end

   // ---------------- target driver tasks ----------------
   task automatic start_txn(input int len);
      for (int k = 0; k < MAXB; k++) i_cmd_bytes[8*k +: 8] = tc[k];
      i_cmd_len = 4'(len);
      i_start   = 1'b1;
      tick(1);
      i_start   = 1'b0;
      chk("sel_after_start",  o_sel, 1);
      chk("busy_after_start", o_busy, 1);
      chk("err_cleared",      o_err, 0);
      chk("count_cleared",    o_data_count, 0);
   endtask

   task automatic select_target(output bit ok);
      tick($urandom_range(0, 3));
      i_bsy = 1'b1;
      wait_sig(SIG_SEL, 1'b0, 3, "sel_release", ok);
   endtask

   task automatic xfer(input logic [2:0] ph, input logic [7:0] val, input int limit,
                       output logic [7:0] got, output bit ok);
      tick($urandom_range(0, 2));
      {i_msg, i_cd, i_io} = ph;
      i_db = val;
      if (ph == PH_DATA) exp_q.push_back(val);
      i_req = 1'b1;
      wait_sig(SIG_ACK, 1'b1, limit, "ack_rise", ok);
      got = o_db;
      if (!ok) begin
         i_req = 1'b0;
         return;
      end
      if (ph == PH_CMD) chk("db_oe_with_ack", o_db_oe, 1);
      tick($urandom_range(0, 2));
      i_req = 1'b0;
      i_db  = 8'($urandom);
      wait_sig(SIG_ACK, 1'b0, 4, "ack_fall", ok);
   endtask

   task automatic finish_txn(input logic [1:0] e_err, input int e_cnt,
                             input logic [7:0] e_st, input logic [7:0] e_ms);
      bit ok;
      tick($urandom_range(0, 2));
      i_bsy = 1'b0;
      wait_sig(SIG_DONE, 1'b1, 5, "done_rise", ok);
      if (!ok) begin
         recover();
         return;
      end
      chk("end_err",     o_err, e_err);
      chk("end_count",   o_data_count, e_cnt);
      chk("end_status",  o_status, e_st);
      chk("end_message", o_message, e_ms);
      tick(1);
      chk("done_one_cycle", o_done, 0);
      chk("idle_not_busy",  o_busy, 0);
      chk("sb_drained",     exp_q.size(), 0);
   endtask

   task automatic expect_abort(input logic [1:0] e_err, input bit e_done, input int limit);
      bit ok;
      int n = 0;
      wait_sig(SIG_RST, 1'b1, limit, "rst_rise", ok);
      if (!ok) begin
         recover();
         return;
      end
      while (o_rst && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rst_cycles", n, RSTC);
      if (e_done) begin
         chk("abort_done_pulse", o_done, 1);
         tick(1);
         chk("abort_done_one_cycle", o_done, 0);
      end else begin
         chk("idle_abort_no_done", o_done, 0);
      end
      chk("abort_err",  o_err, e_err);
      chk("abort_idle", o_busy, 0);
      i_req = 1'b0;
      i_bsy = 1'b0;
   endtask

   // Full well-formed transaction against the descriptor held in tc/td.
   task automatic full_txn(input int len, input int n,
                           input logic [7:0] st, input logic [7:0] ms);
      int eff;
      logic [7:0] got;
      bit ok;
      eff     = (len == 0) ? 1 : len;
      hs_idx  = 0;
      stalled = 1'b0;
      start_txn(len);
      select_target(ok);
      if (!ok) begin recover(); return; end
      for (int k = 0; k < eff; k++) begin
         xfer(PH_CMD, 8'($urandom), 20, got, ok);
         if (!ok) begin recover(); return; end
         chk("cmd_byte", got, tc[k]);
      end
      for (int k = 0; k < n; k++) begin
         xfer(PH_DATA, td[k], 300, got, ok);
         if (!ok) begin recover(); return; end
      end
      xfer(PH_STAT, st, 20, got, ok);
      if (!ok) begin recover(); return; end
      xfer(PH_MSG, ms, 20, got, ok);
      if (!ok) begin recover(); return; end
      finish_txn(2'd0, n, st, ms);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] got;
      bit ok;
      int len, n;
      logic [7:0] st, ms;

      i_rst_n = 1'b0; i_start = 0; i_abort = 0; i_cmd_bytes = '0; i_cmd_len = 0;
      i_bsy = 0; i_req = 0; i_msg = 0; i_cd = 0; i_io = 0; i_db = 0;
      for (int k = 0; k < MAXB; k++) tc[k] = 8'h00;

      // Reset state
      tick(3);
      check_all_zero("in_reset");
      i_rst_n = 1'b1;
      tick(2);
      check_all_zero("after_reset");

      // Reference command/data sequence with literal expectations
      tc[0] = 8'h08; tc[1] = 8'h00; tc[2] = 8'h00; tc[3] = 8'h10; tc[4] = 8'h01; tc[5] = 8'h00;
      td[0] = 8'hA5; td[1] = 8'h5A; td[2] = 8'h00; td[3] = 8'hFF;
      rdy_random = 1'b0;
      full_txn(6, 4, 8'h00, 8'h00);
      chk("ref_count_lit", o_data_count, 16'd4);

      // Consumer stalls 50 cycles on the second DATA_IN byte
      stall_byte = 1;
      full_txn(6, 4, 8'h02, 8'h80);
      chk("stall_happened", stalled, 1);
      chk("stall_status_lit", o_status, 8'h02);
      stall_byte = -1;

      // Randomized well-formed transactions
      rdy_random = 1'b1;
      for (int t = 0; t < 20; t++) begin
         len = $urandom_range(0, MAXB);
         n   = $urandom_range(0, 6);
         for (int k = 0; k < MAXB; k++) tc[k] = 8'($urandom);
         for (int k = 0; k < 8; k++) td[k] = 8'($urandom);
         st = 8'($urandom);
         ms = 8'($urandom);
         full_txn(len, n, st, ms);
         tick($urandom_range(0, 3));
      end
      rdy_random = 1'b0;

      // Target asks for a 7th command byte with a 6-byte block
      for (int k = 0; k < MAXB; k++) tc[k] = 8'($urandom_range(1, 255));
      start_txn(6);
      select_target(ok);
      for (int k = 0; k < 7 && ok; k++) begin
         xfer(PH_CMD, 8'h00, 20, got, ok);
         if (ok) chk("over_cmd_byte", got, (k < 6) ? tc[k] : 8'h00);
      end
      if (ok) expect_abort(2'd3, 1'b1, 3); else recover();

      // Simultaneous start and abort in IDLE: reset pulse only, error kept
      i_start = 1'b1;
      i_abort = 1'b1;
      tick(1);
      i_start = 1'b0;
      i_abort = 1'b0;
      chk("abort_wins_no_sel", o_sel, 0);
      expect_abort(2'd3, 1'b0, 2);

      // Target never raises BSY: selection timeout
      start_txn(1);
      n = 0;
      while (o_sel && n < TIMEOUT + 100) begin
         @(negedge clk);
         n++;
      end
      chk("sel_cycles", n + 1, TIMEOUT + 1);
      expect_abort(2'd1, 1'b1, 2);

      // BSY raised but REQ never comes: handshake timeout
      start_txn(1);
      select_target(ok);
      if (ok) expect_abort(2'd2, 1'b1, TIMEOUT + 20); else recover();

      // External abort while ACK is held for a DATA_IN byte
      tc[0] = 8'h12; td[0] = 8'h3C; td[1] = 8'hC3;
      hs_idx = 0;
      start_txn(1);
      select_target(ok);
      if (ok) xfer(PH_CMD, 8'h00, 20, got, ok);
      if (ok) xfer(PH_DATA, td[0], 50, got, ok);
      if (ok) begin
         {i_msg, i_cd, i_io} = PH_DATA;
         i_db = td[1];
         exp_q.push_back(td[1]);
         i_req = 1'b1;
         wait_sig(SIG_ACK, 1'b1, 50, "abort_ack_rise", ok);
      end
      if (ok) begin
         i_abort = 1'b1;
         tick(1);
         i_abort = 1'b0;
         chk("abort_ack_drop", o_ack, 0);
         chk("abort_rst_now",  o_rst, 1);
         chk("abort_count",    o_data_count, 16'd1);
         expect_abort(2'd0, 1'b1, 2);
         chk("abort_sb_drained", exp_q.size(), 0);
      end else begin
         recover();
      end

      // Asynchronous reset while a command byte is being acknowledged
      tc[0] = 8'h5E;
      start_txn(1);
      select_target(ok);
      if (ok) begin
         {i_msg, i_cd, i_io} = PH_CMD;
         i_req = 1'b1;
         wait_sig(SIG_ACK, 1'b1, 20, "rst_mid_ack_rise", ok);
      end
      if (ok) begin
         chk("pre_rst_db", o_db, 8'h5E);
         #2;
         i_rst_n = 1'b0;
         #1;
         check_all_zero("async_rst");
         i_req = 1'b0;
         i_bsy = 1'b0;
         tick(1);
         i_rst_n = 1'b1;
         exp_q.delete();
         tick(1);
      end else begin
         recover();
      end

      // Recovery transaction after reset
      for (int k = 0; k < MAXB; k++) tc[k] = 8'($urandom);
      td[0] = 8'h11; td[1] = 8'h22;
      full_txn(3, 2, 8'h04, 8'h07);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit
   initial begin
      #1500000;
      failures++;
      $display("FAIL watchdog expired before sequence end");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
